// File: rtl/cordic_sched_pkg.sv
// Shared definitions for the CORDIC NCO scheduler: config select codes,
// default core latency and the tag carried alongside each core request.
package cordic_sched_pkg;

    localparam logic [1:0] CFG_FREQ   = 2'd0;
    localparam logic [1:0] CFG_OFFSET = 2'd1;
    localparam logic [1:0] CFG_EN     = 2'd2;

    localparam int CORDIC_LAT_DEFAULT = 18;

    // Wide enough for the largest supported channel count (16).
    localparam int TAG_CH_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;

endpackage

// File: rtl/cordic_sched_fifo.sv
// Synchronous FIFO with a registered head; a push into an empty FIFO becomes
// visible on the following cycle (no combinational fall-through).
module cordic_sched_fifo #(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] dout_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_vld;
    logic [DATA_W-1:0] r_dout;
    logic              w_load, w_mem_empty, w_mem_rd, w_bypass, w_mem_wr;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Head register reloads when empty or being popped; an empty backing
    // store lets the incoming word go straight into the head.
    always_comb begin
        w_load      = !r_vld || ready_i;
        w_mem_empty = (r_cnt == '0);
        w_mem_rd    = w_load && !w_mem_empty;
        w_bypass    = w_load && w_mem_empty && push_i;
        w_mem_wr    = push_i && !w_bypass;
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_wr) r_mem[r_wr_ptr] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            r_dout   <= '0;
        end else begin
            if (w_mem_wr) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_mem_rd) r_rd_ptr <= f_inc(r_rd_ptr);
            r_cnt <= r_cnt + CNT_W'(w_mem_wr) - CNT_W'(w_mem_rd);
            if (w_mem_rd) begin
                r_dout <= r_mem[r_rd_ptr];
                r_vld  <= 1'b1;
            end else if (w_bypass) begin
                r_dout <= din_i;
                r_vld  <= 1'b1;
            end else if (w_load) begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign valid_o = r_vld;
    assign dout_o  = r_dout;

endmodule

// File: rtl/cordic_nco_sched.sv
// Round-robin NCO scheduler time-sharing one CORDIC core across N_CH channels.
// Define CORDIC_SCHED_STATS_EN to add stall_cnt_o (cycles blocked by credit).
module cordic_nco_sched
    import cordic_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CORDIC_LAT = CORDIC_LAT_DEFAULT,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_we_i,
    input  logic [$clog2(N_CH)-1:0] cfg_ch_i,
    input  logic [1:0]              cfg_sel_i,
    input  logic [31:0]             cfg_data_i,
    output logic                    cordic_valid_o,
    output logic [31:0]             cordic_phase_o,
    input  logic                    cordic_valid_i,
    input  logic signed [15:0]      cordic_sin_i,
    input  logic signed [15:0]      cordic_cos_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [$clog2(N_CH)-1:0] m_ch_o,
    output logic signed [15:0]      m_sin_o,
    output logic signed [15:0]      m_cos_o,
`ifdef CORDIC_SCHED_STATS_EN
    output logic [31:0]             stall_cnt_o,
`endif
    output logic                    err_o
);
    localparam int CH_W = $clog2(N_CH);
    localparam int CR_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int FD_W = CH_W + 32;

    logic [31:0]     r_freq   [N_CH];
    logic [31:0]     r_offset [N_CH];
    logic [31:0]     r_acc    [N_CH];
    logic [N_CH-1:0] r_en;
    logic [CH_W-1:0] r_last, r_ch_p1;
    logic            r_vld_p1;
    logic [31:0]     r_phase_p1;
    tag_t            r_tag    [CORDIC_LAT];
    logic [CR_W-1:0] r_credit;
    logic            r_err;

    logic [CH_W-1:0] w_sel, w_idx;
    logic            w_found, w_credit_ok, w_issue;
    tag_t            w_head;
    logic            w_push, w_lost, w_orphan, w_pop;
    logic [FD_W-1:0] w_fifo_din, w_fifo_dout;
    logic            w_unused_ch;

    // Stage p0: pick the first enabled channel strictly after the last issued one.
    always_comb begin
        w_sel   = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = CH_W'((int'(r_last) + i) % N_CH);
            if (!w_found && r_en[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
        w_credit_ok = (r_credit < CR_W'(FIFO_DEPTH));
        w_issue     = w_found && w_credit_ok;
    end

    // A 0->1 enable never coincides with an issue of that channel, so the
    // accumulator clear and advance cannot collide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                r_freq[c]   <= '0;
                r_offset[c] <= '0;
                r_acc[c]    <= '0;
            end
            r_en <= '0;
        end else begin
            if (w_issue) r_acc[w_sel] <= r_acc[w_sel] + r_freq[w_sel];
            if (cfg_we_i && (int'(cfg_ch_i) < N_CH)) begin
                case (cfg_sel_i)
                    CFG_FREQ:   r_freq[cfg_ch_i]   <= cfg_data_i;
                    CFG_OFFSET: r_offset[cfg_ch_i] <= cfg_data_i;
                    CFG_EN: begin
                        r_en[cfg_ch_i] <= cfg_data_i[0];
                        if (cfg_data_i[0] && !r_en[cfg_ch_i]) r_acc[cfg_ch_i] <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage p1: registered request to the core.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p1   <= 1'b0;
            r_phase_p1 <= '0;
            r_ch_p1    <= '0;
            r_last     <= CH_W'(N_CH - 1);
        end else begin
            r_vld_p1 <= w_issue;
            if (w_issue) begin
                r_phase_p1 <= r_acc[w_sel] + r_offset[w_sel];
                r_ch_p1    <= w_sel;
                r_last     <= w_sel;
            end
        end
    end

    assign cordic_valid_o = r_vld_p1;
    assign cordic_phase_o = r_phase_p1;

    // Tag line: the head lines up with the core's result for the same request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CORDIC_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= '{valid: r_vld_p1, ch: TAG_CH_W'(r_ch_p1)};
            for (int i = 1; i < CORDIC_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_comb begin
        w_head   = r_tag[CORDIC_LAT-1];
        w_push   = cordic_valid_i && w_head.valid;
        w_lost   = w_head.valid && !cordic_valid_i;
        w_orphan = cordic_valid_i && !w_head.valid;
        w_pop    = m_valid_o && m_ready_i;
    end

    assign w_unused_ch = ^w_head.ch;
    assign w_fifo_din  = {CH_W'(w_head.ch), cordic_sin_i, cordic_cos_i};

    // Credit covers every request from issue until it leaves the FIFO or is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credit <= '0;
            r_err    <= 1'b0;
        end else begin
            r_credit <= r_credit + CR_W'(w_issue) - CR_W'(w_pop) - CR_W'(w_lost);
            if (w_orphan || w_lost) r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    cordic_sched_fifo #(
        .DATA_W (FD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .din_i   (w_fifo_din),
        .ready_i (m_ready_i),
        .valid_o (m_valid_o),
        .dout_o  (w_fifo_dout)
    );

    assign {m_ch_o, m_sin_o, m_cos_o} = w_fifo_dout;

`ifdef CORDIC_SCHED_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_stall_cnt <= '0;
        else if (w_found && !w_credit_ok) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cordic_nco_sched.sv
// Directed bench for cordic_nco_sched with a behavioural fixed-latency core
// that returns quadrant sin/cos for multiples of pi/2 and raw phase bits otherwise.
`timescale 1ns/1ps
module tb_cordic_nco_sched;
    import cordic_sched_pkg::*;

    localparam int N_CH  = 4;
    localparam int LAT   = 18;
    localparam int DEPTH = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_ch = '0;
    logic [1:0]         cfg_sel = '0;
    logic [31:0]        cfg_data = '0;
    logic               cordic_valid_o;
    logic [31:0]        cordic_phase_o;
    logic               cordic_valid_i;
    logic signed [15:0] cordic_sin_i, cordic_cos_i;
    logic               m_valid, m_ready = 1'b1;
    logic [1:0]         m_ch;
    logic signed [15:0] m_sin, m_cos;
    logic               err;
    logic               inj = 1'b0;
`ifdef CORDIC_SCHED_STATS_EN
    logic [31:0]        stall_cnt;
`endif

    int n_run = 0;
    int n_fail = 0;
    logic credit_ovf = 1'b0;

    always #5 clk = ~clk;

    cordic_nco_sched #(.N_CH(N_CH), .CORDIC_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_we_i       (cfg_we),
        .cfg_ch_i       (cfg_ch),
        .cfg_sel_i      (cfg_sel),
        .cfg_data_i     (cfg_data),
        .cordic_valid_o (cordic_valid_o),
        .cordic_phase_o (cordic_phase_o),
        .cordic_valid_i (cordic_valid_i),
        .cordic_sin_i   (cordic_sin_i),
        .cordic_cos_i   (cordic_cos_i),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_ch_o         (m_ch),
        .m_sin_o        (m_sin),
        .m_cos_o        (m_cos),
`ifdef CORDIC_SCHED_STATS_EN
        .stall_cnt_o    (stall_cnt),
`endif
        .err_o          (err)
    );

    function automatic logic signed [15:0] f_sin(input logic [31:0] p);
        if (p[29:0] != '0) return p[31:16];
        case (p[31:30])
            2'd1:    return 16'sd32767;
            2'd3:    return -16'sd32767;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] f_cos(input logic [31:0] p);
        if (p[29:0] != '0) return p[15:0];
        case (p[31:30])
            2'd0:    return 16'sd32767;
            2'd2:    return -16'sd32767;
            default: return 16'sd0;
        endcase
    endfunction

    // Behavioural core: fixed LAT pipeline, cleared by the shared reset.
    logic [LAT-1:0] core_v = '0;
    logic [31:0]    core_p [LAT];

    always @(posedge clk) begin
        if (rst) begin
            core_v <= '0;
        end else begin
            core_v    <= {core_v[LAT-2:0], cordic_valid_o};
            core_p[0] <= cordic_phase_o;
            for (int i = 1; i < LAT; i++) core_p[i] <= core_p[i-1];
        end
    end

    assign cordic_valid_i = core_v[LAT-1] | inj;
    assign cordic_sin_i   = inj ? 16'sh7777 : f_sin(core_p[LAT-1]);
    assign cordic_cos_i   = inj ? 16'sh7777 : f_cos(core_p[LAT-1]);

    always @(negedge clk) begin
        assert (dut.r_credit <= DEPTH) else credit_ovf <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_mvalid(input string tag, input int budget);
        int k = 0;
        while (!m_valid && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(m_valid), 1);
    endtask

    logic [31:0] exp_ph1  [5] = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    int          exp_ch2  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int          exp_sin2 [8] = '{0, 0, 0, 0, 'h1000, 'h2000, 'h3000, 32767};
    int          exp_cos2 [8] = '{32767, 32767, 32767, 32767, 0, 0, 0, 0};
    int          exp_sin4 [3] = '{'h0800, 'h1800, 'h2800};

    initial begin
        int cnt;
        int ns;
        int cap_ch  [8];
        int cap_sin [8];

        repeat (3) tick();
        check("rst_cvalid", 32'(cordic_valid_o), 0);
        check("rst_phase", cordic_phase_o, 0);
        check("rst_mvalid", 32'(m_valid), 0);
        check("rst_mch", 32'(m_ch), 0);
        check("rst_msin", m_sin, 0);
        check("rst_mcos", m_cos, 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;

        // Single channel, quarter-turn steps.
        cfg(2'd0, CFG_FREQ, 32'h4000_0000);
        cfg(2'd0, CFG_EN, 32'd1);
        check("t1_not_yet", 32'(cordic_valid_o), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t1_vld%0d", i), 32'(cordic_valid_o), 1);
            check($sformatf("t1_ph%0d", i), cordic_phase_o, exp_ph1[i]);
        end
        repeat (14) tick();
        check("t1_lat_early", 32'(m_valid), 0);
        tick();
        check("t1_lat", 32'(m_valid), 1);
        check("t1_ch", 32'(m_ch), 0);
        check("t1_sin0", m_sin, 0);
        check("t1_cos0", m_cos, 32767);
        tick();
        check("t1_sin1", m_sin, 32767);
        check("t1_cos1", m_cos, 0);
        tick();
        check("t1_sin2", m_sin, 0);
        check("t1_cos2", m_cos, -32767);
        tick();
        check("t1_sin3", m_sin, -32767);
        cfg(2'd0, CFG_EN, 32'd0);
        repeat (30) tick();
        check("t1_drained", 32'(m_valid), 0);
        check("t1_err", 32'(err), 0);

        // Four channels round-robin.
        for (int c = 0; c < N_CH; c++) cfg(2'(c), CFG_FREQ, 32'(32'h1000_0000 * (c + 1)));
        for (int c = 0; c < N_CH; c++) cfg(2'(c), CFG_EN, 32'd1);
        wait_mvalid("t2_wait", 40);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_ch%0d", i), 32'(m_ch), exp_ch2[i]);
            check($sformatf("t2_sin%0d", i), m_sin, exp_sin2[i]);
            check($sformatf("t2_cos%0d", i), m_cos, exp_cos2[i]);
            tick();
        end
        for (int c = 0; c < N_CH; c++) cfg(2'(c), CFG_EN, 32'd0);
        repeat (30) tick();
        check("t2_drained", 32'(m_valid), 0);

        // Backpressure: credit stops issue at FIFO_DEPTH.
        cfg(2'd0, CFG_FREQ, 32'h0100_0000);
        m_ready = 1'b0;
        cfg(2'd0, CFG_EN, 32'd1);
        cnt = 0;
        repeat (80) begin
            tick();
            if (cordic_valid_o) cnt++;
        end
        check("t3_issued", cnt, DEPTH);
        check("t3_blocked", 32'(cordic_valid_o), 0);
        check("t3_credit", 32'(dut.r_credit), DEPTH);
        check("t3_head_vld", 32'(m_valid), 1);
        check("t3_head0", m_sin, 0);
        tick();
        check("t3_head_hold", m_sin, 0);
        m_ready = 1'b1;
        tick();
        check("t3_no_early", 32'(cordic_valid_o), 0);
        check("t3_head1", m_sin, 'h100);
        tick();
        check("t3_resume", 32'(cordic_valid_o), 1);
        check("t3_resume_ph", cordic_phase_o, 32'h2000_0000);
        for (int k = 2; k < 40; k++) begin
            wait_mvalid($sformatf("t3_wait%0d", k), 40);
            check($sformatf("t3_sin%0d", k), m_sin, 32'(k * 'h100));
            check($sformatf("t3_ch%0d", k), 32'(m_ch), 0);
            tick();
        end
        cfg(2'd0, CFG_EN, 32'd0);
        repeat (40) tick();
        check("t3_drained", 32'(m_valid), 0);

        // Disable with samples in flight, then re-enable.
        cfg(2'd1, CFG_FREQ, 32'h1000_0000);
        cfg(2'd1, CFG_OFFSET, 32'h0800_0000);
        cfg(2'd1, CFG_EN, 32'd1);
        cnt = 0;
        ns = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) cfg(2'd1, CFG_EN, 32'd0);
            else tick();
            if (cordic_valid_o) cnt++;
            if (m_valid && m_ready && ns < 8) begin
                cap_ch[ns]  = int'(m_ch);
                cap_sin[ns] = int'(m_sin);
                ns++;
            end
        end
        check("t4_issued", cnt, 3);
        check("t4_delivered", ns, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_ch%0d", i), cap_ch[i], 1);
            check($sformatf("t4_sin%0d", i), cap_sin[i], exp_sin4[i]);
        end
        cfg(2'd1, CFG_EN, 32'd1);
        tick();
        check("t4_reen_vld", 32'(cordic_valid_o), 1);
        check("t4_reen_ph", cordic_phase_o, 32'h0800_0000);
        cfg(2'd1, CFG_EN, 32'd0);
        repeat (40) tick();
        check("t4_err", 32'(err), 0);

        // Orphan result with an empty tag line.
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check("t5_err", 32'(err), 1);
        check("t5_dropped", 32'(m_valid), 0);
        repeat (5) tick();
        check("t5_sticky", 32'(err), 1);

        // Reset mid-stream.
        cfg(2'd0, CFG_EN, 32'd1);
        cfg(2'd2, CFG_EN, 32'd1);
        m_ready = 1'b0;
        repeat (25) tick();
        check("t6_pre_vld", 32'(m_valid), 1);
        rst = 1'b1;
        tick();
        check("t6_cvalid", 32'(cordic_valid_o), 0);
        check("t6_phase", cordic_phase_o, 0);
        check("t6_mvalid", 32'(m_valid), 0);
        check("t6_msin", m_sin, 0);
        check("t6_err", 32'(err), 0);
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (LAT + 5) tick();
        check("t6_no_stale", 32'(m_valid), 0);
        check("t6_no_err", 32'(err), 0);
        cfg(2'd0, CFG_OFFSET, 32'h0000_1234);
        cfg(2'd0, CFG_EN, 32'd1);
        tick();
        check("t6_first_vld", 32'(cordic_valid_o), 1);
        check("t6_first_ph", cordic_phase_o, 32'h0000_1234);
        wait_mvalid("t6_wait", 40);
        check("t6_mch", 32'(m_ch), 0);
        check("t6_msin", m_sin, 0);
        check("t6_mcos", m_cos, 32'h1234);

        check("credit_bound", 32'(credit_ovf), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_nco_sched.md
# cordic_nco_sched

Multi-channel NCO scheduler that time-shares one `cordic` sin/cos core between N independently configured channels. Holds a per-channel frequency word, phase offset and phase accumulator, issues one channel per cycle to the core in round-robin order, and tracks each request's channel through the core's fixed latency. Results land in a credit-protected output FIFO drained by a valid/ready stream. Sits between the register/config interface and the mixer/DUC datapath.

## Interface
- `N_CH`, 4: number of channels (2..16).
- `CORDIC_LAT`, 18: cycles from `cordic_valid_o` high to matching `cordic_valid_i` high.
- `FIFO_DEPTH`, 32: output FIFO entries; must be ≥ 2.
- `clk_i` in 1: sole clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cfg_we_i` in 1: config write strobe.
- `cfg_ch_i` in $clog2(N_CH): target channel.
- `cfg_sel_i` in 2: 0 = freq word, 1 = phase offset, 2 = enable (bit 0), 3 = reserved (ignored).
- `cfg_data_i` in 32: write data.
- `cordic_valid_o` out 1: request to core.
- `cordic_phase_o` out 32: phase to core (2^32 = 2π).
- `cordic_valid_i` in 1: core result valid.
- `cordic_sin_i`, `cordic_cos_i` in 16 signed: core results.
- `m_valid_o` out 1, `m_ready_i` in 1: output stream handshake.
- `m_ch_o` out $clog2(N_CH); `m_sin_o`, `m_cos_o` out 16 signed: output sample.
- `err_o` out 1: sticky, result arrived with no matching tag.

## Operation
- Per channel: `freq`, `offset`, `acc` (32 b), `en`. All zero after reset.
- Issue condition: at least one channel enabled AND `credit < FIFO_DEPTH`, where `credit` counts in-flight requests plus FIFO occupancy.
- Round-robin selection: the first enabled channel strictly after the last issued channel, wrapping. A single enabled channel issues every cycle while credit allows. With no channels enabled, nothing issues.
- On issue of channel c: `cordic_phase_o <= acc[c] + offset[c]` (mod 2^32), `cordic_valid_o <= 1`, `acc[c] <= acc[c] + freq[c]`, and the tag c is pushed into the tag delay line.
- Tag delay line is `CORDIC_LAT` deep and carries {valid, ch}. On `cordic_valid_i`, the head tag's ch, together with sin/cos, is written to the FIFO. If `cordic_valid_i` is high while the head tag is invalid, set `err_o` and drop the result. A valid head tag with `cordic_valid_i` low also sets `err_o`, and its credit is released.
- Credit: +1 on issue, −1 on FIFO pop (`m_valid_o & m_ready_i`). Both in the same cycle leave it unchanged. An overflow is unreachable by construction; the bench asserts this.
- Config writes:
  - A write to `en` with a 0→1 transition clears `acc[c]` to 0.
  - Disabling a channel stops new issues only. In-flight samples for that channel are still delivered.
  - A write in cycle k is seen by the issue decision in cycle k+1. An issue in cycle k uses pre-write values.
  - A disable write in the same cycle as that channel's issue: the issue proceeds and `acc` advances.

## Timing
- Reset values: `cordic_valid_o`=0, `cordic_phase_o`=0, `m_valid_o`=0, `m_ch_o`/`m_sin_o`/`m_cos_o`=0, `err_o`=0. Reset also clears tag line, FIFO, credit and RR pointer (pointer set to N_CH−1, so ch0 wins first).
- `cordic_valid_o` and `cordic_phase_o` are registered, one cycle after the issue decision.
- Result written into the FIFO at the edge where `cordic_valid_i` is sampled. `m_valid_o` rises on the next cycle (no fall-through). Latency from `cordic_valid_o` to `m_valid_o` = CORDIC_LAT+1.
- The FIFO head is stable while `m_valid_o & !m_ready_i`.
- Reset mid-operation: all state clears in one cycle. The shared core is reset by the same `rst_i`, so no stale results return.

## Configuration
- `CORDIC_SCHED_STATS_EN` defined: adds output `stall_cnt_o` [31:0]. It increments (wrapping) on every cycle where a channel is enabled but issue is blocked by credit, and clears on reset.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- `cordic_sched_pkg` holds:
  - the `cfg_sel` encodings (`CFG_FREQ`, `CFG_OFFSET`, `CFG_EN`);
  - the default `CORDIC_LAT` constant;
  - the `tag_t` typedef {valid, ch}.
- Sub-module `cordic_sched_fifo` is a synchronous FIFO, registered output, parameterised width/depth. The scheduler, accumulators, tag line and credit logic live in the top.

## Test plan
- ch0 only: freq=0x4000_0000, offset=0, enable → `cordic_phase_o` sequence 0x0, 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0 on consecutive cycles; `m_ch_o`=0, sin ≈ 0,+max,0,−max.
- ch0..ch3 enabled, freq=0x1000_0000·(c+1) → issue order 0,1,2,3,0,…; each `m_ch_o` paired with its own phase, per the golden model.
- `m_ready_i`=0 with ch0 enabled → exactly FIFO_DEPTH samples issued, then `cordic_valid_o` stays 0; raise ready → issues resume one cycle after the first pop; no loss.
- Disable ch1 while its samples are in flight → those samples still appear; no further ch1 issues; re-enable → ch1 phase restarts at `offset`.
- Inject `cordic_valid_i` pulse with empty tag line → `err_o`=1 and stays 1 until `rst_i`.
- Assert `rst_i` mid-stream → next cycle all outputs 0, `m_valid_o`=0; after release, first issue is ch0 with phase = offset.
